cmos_power_seq: RTL and testbench
=================================

# cmos_power_seq

Parametrised power sequencer for the CMOS sensor, sitting between the system reset and the sensor's PWDN/RESET pins. It drives the power-up order (hold PWDN, release PWDN, release RESET, wait for init) and reports when the sensor is ready. Unlike a fixed power-on-only controller, it also has:
- a runtime enable with an orderly power-down sequence,
- abort of power-up when the enable drops,
- delays derived from the clock frequency,
- state and busy status.

SCCB configuration is gated on `power_done`.

## Interface
- CLK_HZ, 50_000_000, clock frequency in Hz; CYC_US = CLK_HZ/1_000_000 (integer division).
- T_PWDN_US, 6000, PWDN-asserted hold before release.
- T_RST_US, 2000, RESET-asserted hold after PWDN release.
- T_INIT_US, 21000, wait after RESET release before ready.
- T_OFF_US, 1000, RESET-asserted hold before re-asserting PWDN on shutdown.
- Derived: N_x = max(1, CYC_US*T_x_US). The shared counter width is clog2(max N_x)+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  level; 1 requests sensor powered, 0 requests powered down.
- cmos_pwdn  out  1  sensor power-down pin, active high.
- cmos_rst_n  out  1  sensor reset pin, active low.
- power_done  out  1  sensor ready for configuration.
- busy  out  1  sequence in progress (timed state).
- state  out  3  current state encoding.

## Operation
States, as encoding: name (pwdn/rst_n/done) -> transitions.
- 0 OFF (1/0/0): go to PWDN_HOLD when en=1.
- 1 PWDN_HOLD (1/0/0):
  - after N_PWDN cycles -> RST_HOLD.
  - en=0 -> OFF immediately. The pins are unchanged, so no shutdown hold is needed.
- 2 RST_HOLD (0/0/0):
  - after N_RST cycles -> INIT_WAIT.
  - en=0 -> SHUT.
- 3 INIT_WAIT (0/1/0):
  - after N_INIT cycles -> READY.
  - en=0 -> SHUT.
- 4 READY (0/1/1): en=0 -> SHUT.
- 5 SHUT (0/0/0):
  - after N_OFF cycles -> OFF.
  - Always runs to completion; en is ignored while in SHUT.
- Encodings 6–7 are illegal and recover to OFF on the next edge with OFF outputs.

Counter and output rules:
- A single counter clears to 0 on every state entry and increments each cycle in timed states (1, 2, 3, 5). A timed state is left on the edge where the counter equals N_x−1, so it lasts exactly N_x cycles.
- An en=0 abort has priority over timer expiry on the same edge.
- busy=1 in states 1, 2, 3 and 5.
- All outputs are registered, loaded from the next-state decode, so pins change on the same edge as `state` with no combinational glitches.

## Timing
- Reset (async assert, sync use on release): state=OFF, cmos_pwdn=1, cmos_rst_n=0, power_done=0, busy=0, counter=0.
- en is sampled on each rising edge. en=1 held from reset release (edge 1 = first edge after release) gives:
  - PWDN_HOLD at edge 1.
  - cmos_pwdn falls at edge N_PWDN+1.
  - cmos_rst_n rises at edge N_PWDN+N_RST+1.
  - power_done rises at edge N_PWDN+N_RST+N_INIT+1.
  - Defaults at 50 MHz: edges 300001, 400001, 1450001.
- Shutdown from READY (en=0 sampled at edge k):
  - cmos_rst_n=0 and power_done=0 at edge k.
  - cmos_pwdn=1 at edge k+N_OFF.
- cmos_pwdn=0 with cmos_rst_n=0 never lasts less than N_RST (power-up) or N_OFF (shutdown), except in the en=0 abort from RST_HOLD, which enters SHUT.
- en re-asserted during SHUT: SHUT completes, OFF holds for 1 cycle, then PWDN_HOLD.
- en glitch of one cycle in READY causes a full SHUT→OFF→power-up cycle.

## Test plan
Common bench parameters: CLK_HZ=1_000_000, T_PWDN_US=4, T_RST_US=2, T_INIT_US=3, T_OFF_US=2.
- Power-up: en=1 from reset release -> cmos_pwdn falls at edge 5, cmos_rst_n rises at edge 7, power_done at edge 10. busy=1 on edges 1–9 and 0 from edge 10. state follows 1,2,3,4.
- Shutdown: en=0 sampled at edge 20 in READY -> state 5, rst_n=0, done=0 at edge 20; cmos_pwdn=1, state 0 at edge 22.
- Aborts:
  - en=0 sampled at edge 3 (PWDN_HOLD) -> OFF at edge 3, pins unchanged.
  - en=0 sampled at edge 6 (RST_HOLD) -> SHUT at edge 6, OFF at edge 8.
- Re-enable during SHUT: en back to 1 one cycle after entering SHUT -> OFF at +2, PWDN_HOLD at +3, then full sequence repeats with identical spacing.
- Async reset mid-INIT_WAIT: assert rst_n=0 between edges -> outputs immediately return to reset values. After release with en=1, the sequence restarts from edge 1 timing.
- Degenerate timing: T_RST_US=0 -> RST_HOLD lasts exactly 1 cycle (rst_n rises 1 edge after pwdn falls). Also force state to 7 -> OFF on the next edge.

Source files
------------

// File: rtl/cmos_power_seq.sv
// rtl/cmos_power_seq.sv - CMOS sensor PWDN/RESET power sequencer with enable-driven shutdown
module cmos_power_seq #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int T_PWDN_US = 6000,
    parameter int T_RST_US  = 2000,
    parameter int T_INIT_US = 21000,
    parameter int T_OFF_US  = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       cmos_pwdn,
    output logic       cmos_rst_n,
    output logic       power_done,
    output logic       busy,
    output logic [2:0] state
);
    localparam int CYC_US  = CLK_HZ / 1_000_000;
    localparam int N_PWDN  = (CYC_US * T_PWDN_US < 1) ? 1 : CYC_US * T_PWDN_US;
    localparam int N_RST   = (CYC_US * T_RST_US  < 1) ? 1 : CYC_US * T_RST_US;
    localparam int N_INIT  = (CYC_US * T_INIT_US < 1) ? 1 : CYC_US * T_INIT_US;
    localparam int N_OFF   = (CYC_US * T_OFF_US  < 1) ? 1 : CYC_US * T_OFF_US;
    localparam int N_MAX_A = (N_PWDN > N_RST) ? N_PWDN : N_RST;
    localparam int N_MAX_B = (N_INIT > N_OFF) ? N_INIT : N_OFF;
    localparam int N_MAX   = (N_MAX_A > N_MAX_B) ? N_MAX_A : N_MAX_B;
    localparam int CW      = $clog2(N_MAX) + 1;

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_PWDN_HOLD = 3'd1,
        S_RST_HOLD  = 3'd2,
        S_INIT_WAIT = 3'd3,
        S_READY     = 3'd4,
        S_SHUT      = 3'd5
    } state_t;

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_pwdn;
    logic          r_rst_n;
    logic          r_done;
    logic          r_busy;

    state_t        w_next;
    logic [CW-1:0] w_limit;
    logic          w_expired;
    logic          w_pwdn;
    logic          w_rst_n;
    logic          w_done;
    logic          w_busy;

    // Abort on en=0 is tested before timer expiry so it wins on a shared edge.
    always_comb begin
        w_limit   = '0;
        w_next    = S_OFF;
        case (state_t'(r_state))
            S_PWDN_HOLD: w_limit = CW'(N_PWDN - 1);
            S_RST_HOLD:  w_limit = CW'(N_RST - 1);
            S_INIT_WAIT: w_limit = CW'(N_INIT - 1);
            S_SHUT:      w_limit = CW'(N_OFF - 1);
            default:     w_limit = '0;
        endcase
        w_expired = (r_cnt == w_limit);

        case (state_t'(r_state))
            S_OFF:       w_next = en ? S_PWDN_HOLD : S_OFF;
            S_PWDN_HOLD: w_next = !en ? S_OFF  : (w_expired ? S_RST_HOLD  : S_PWDN_HOLD);
            S_RST_HOLD:  w_next = !en ? S_SHUT : (w_expired ? S_INIT_WAIT : S_RST_HOLD);
            S_INIT_WAIT: w_next = !en ? S_SHUT : (w_expired ? S_READY     : S_INIT_WAIT);
            S_READY:     w_next = !en ? S_SHUT : S_READY;
            S_SHUT:      w_next = w_expired ? S_OFF : S_SHUT;
            default:     w_next = S_OFF;
        endcase
    end

    always_comb begin
        w_pwdn  = 1'b1;
        w_rst_n = 1'b0;
        w_done  = 1'b0;
        w_busy  = 1'b0;
        case (w_next)
            S_PWDN_HOLD: w_busy = 1'b1;
            S_RST_HOLD: begin
                w_pwdn = 1'b0;
                w_busy = 1'b1;
            end
            S_INIT_WAIT: begin
                w_pwdn  = 1'b0;
                w_rst_n = 1'b1;
                w_busy  = 1'b1;
            end
            S_READY: begin
                w_pwdn  = 1'b0;
                w_rst_n = 1'b1;
                w_done  = 1'b1;
            end
            S_SHUT: begin
                w_pwdn = 1'b0;
                w_busy = 1'b1;
            end
            default: begin
                w_pwdn  = 1'b1;
                w_rst_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= 3'd0;
            r_cnt   <= '0;
            r_pwdn  <= 1'b1;
            r_rst_n <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (3'(w_next) != r_state) begin
                r_cnt <= '0;
            end else if (w_busy) begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_pwdn  <= w_pwdn;
            r_rst_n <= w_rst_n;
            r_done  <= w_done;
            r_busy  <= w_busy;
        end
    end

    assign state      = r_state;
    assign cmos_pwdn  = r_pwdn;
    assign cmos_rst_n = r_rst_n;
    assign power_done = r_done;
    assign busy       = r_busy;
endmodule

// File: tb/tb_cmos_power_seq.sv
// tb/tb_cmos_power_seq.sv - bench for cmos_power_seq: vector table, corner sequences, random vs model
module tb_cmos_power_seq;
    logic       clk;
    logic       rst_n;
    logic       en;
    logic       en2;
    logic       cmos_pwdn, cmos_rst_n, power_done, busy;
    logic [2:0] state;
    logic       pw2, rn2, dn2, bs2;
    logic [2:0] st2;

    int pass_cnt = 0;
    int total_cnt = 0;

    cmos_power_seq #(.CLK_HZ(1_000_000), .T_PWDN_US(4), .T_RST_US(2), .T_INIT_US(3), .T_OFF_US(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cmos_pwdn(cmos_pwdn), .cmos_rst_n(cmos_rst_n),
        .power_done(power_done), .busy(busy), .state(state));

    cmos_power_seq #(.CLK_HZ(1_000_000), .T_PWDN_US(4), .T_RST_US(0), .T_INIT_US(3), .T_OFF_US(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .cmos_pwdn(pw2), .cmos_rst_n(rn2),
        .power_done(dn2), .busy(bs2), .state(st2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] pk(input int st, input bit pw, input bit rn, input bit dn, input bit bs);
        return {3'(st), pw, rn, dn, bs};
    endfunction

    function automatic logic [6:0] obs1();
        return {state, cmos_pwdn, cmos_rst_n, power_done, busy};
    endfunction

    function automatic logic [6:0] obs2();
        return {st2, pw2, rn2, dn2, bs2};
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got st/pw/rn/dn/bs=%b expected %b at %0t", name, act, exp, $time);
    endtask

    // Reference model: per-state durations and pin tables, counting remaining cycles down.
    int dur[6]    = '{0, 4, 2, 3, 0, 2};
    bit pw_t[6]   = '{1, 1, 0, 0, 0, 0};
    bit rn_t[6]   = '{0, 0, 0, 1, 1, 0};
    bit dn_t[6]   = '{0, 0, 0, 0, 1, 0};
    bit bs_t[6]   = '{0, 1, 1, 1, 0, 1};
    int m_st;
    int m_left;

    always @(posedge clk or negedge rst_n) begin
        int nxt;
        if (!rst_n) begin
            m_st = 0;
            m_left = 0;
        end else begin
            nxt = m_st;
            if (m_st == 0)      nxt = en ? 1 : 0;
            else if (m_st == 4) nxt = en ? 4 : 5;
            else if (m_st == 5) nxt = (m_left == 1) ? 0 : 5;
            else if (!en)       nxt = (m_st == 1) ? 0 : 5;
            else if (m_left == 1) nxt = m_st + 1;
            if (nxt != m_st) begin
                m_st = nxt;
                m_left = dur[nxt];
            end else if (m_left > 0) begin
                m_left--;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) check("model", obs1(), pk(m_st, pw_t[m_st], rn_t[m_st], dn_t[m_st], bs_t[m_st]));
    end

    typedef struct {
        bit       en;
        int       st;
        bit       pw;
        bit       rn;
        bit       dn;
        bit       bs;
    } vec_t;
    vec_t vec[22];

    task automatic reset_start(input bit e1, input bit e2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        en = e1;
        en2 = e2;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++)   vec[i] = '{1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 4; i < 6; i++)   vec[i] = '{1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 6; i < 9; i++)   vec[i] = '{1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 9; i < 19; i++)  vec[i] = '{1'b1, 4, 1'b0, 1'b1, 1'b1, 1'b0};
        vec[19] = '{1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[20] = '{1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[21] = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        en = 1'b0;
        en2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", obs1(), pk(0, 1, 0, 0, 0));
        check("reset2", obs2(), pk(0, 1, 0, 0, 0));

        // Power-up then shutdown from READY, en=1 during SHUT ignored
        reset_start(vec[0].en, 1'b0);
        for (int i = 0; i < 22; i++) begin
            en = vec[i].en;
            step();
            check($sformatf("vec_edge%0d", i + 1), obs1(),
                  pk(vec[i].st, vec[i].pw, vec[i].rn, vec[i].dn, vec[i].bs));
        end

        // Abort in PWDN_HOLD
        reset_start(1'b1, 1'b0);
        repeat (2) step();
        en = 1'b0;
        step();
        check("abort_pwdn_e3", obs1(), pk(0, 1, 0, 0, 0));
        step();
        check("abort_pwdn_e4", obs1(), pk(0, 1, 0, 0, 0));

        // Abort in RST_HOLD
        reset_start(1'b1, 1'b0);
        repeat (5) step();
        en = 1'b0;
        step();
        check("abort_rst_e6", obs1(), pk(5, 0, 0, 0, 1));
        step();
        check("abort_rst_e7", obs1(), pk(5, 0, 0, 0, 1));
        step();
        check("abort_rst_e8", obs1(), pk(0, 1, 0, 0, 0));

        // Re-enable one cycle into SHUT
        reset_start(1'b1, 1'b0);
        repeat (12) step();
        en = 1'b0;
        step();
        check("reen_k", obs1(), pk(5, 0, 0, 0, 1));
        en = 1'b1;
        step();
        check("reen_k1", obs1(), pk(5, 0, 0, 0, 1));
        step();
        check("reen_k2", obs1(), pk(0, 1, 0, 0, 0));
        step();
        check("reen_k3", obs1(), pk(1, 1, 0, 0, 1));
        repeat (3) step();
        check("reen_k6", obs1(), pk(1, 1, 0, 0, 1));
        step();
        check("reen_k7", obs1(), pk(2, 0, 0, 0, 1));
        repeat (2) step();
        check("reen_k9", obs1(), pk(3, 0, 1, 0, 1));
        repeat (2) step();
        check("reen_k11", obs1(), pk(3, 0, 1, 0, 1));
        step();
        check("reen_k12", obs1(), pk(4, 0, 1, 1, 0));

        // Async reset mid-INIT_WAIT, then restart timing
        reset_start(1'b1, 1'b0);
        repeat (8) step();
        check("pre_areset", obs1(), pk(3, 0, 1, 0, 1));
        #3;
        rst_n = 1'b0;
        #1;
        check("areset_immediate", obs1(), pk(0, 1, 0, 0, 0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) step();
        check("restart_e4", obs1(), pk(1, 1, 0, 0, 1));
        step();
        check("restart_e5", obs1(), pk(2, 0, 0, 0, 1));
        repeat (2) step();
        check("restart_e7", obs1(), pk(3, 0, 1, 0, 1));
        repeat (2) step();
        check("restart_e9", obs1(), pk(3, 0, 1, 0, 1));
        step();
        check("restart_e10", obs1(), pk(4, 0, 1, 1, 0));

        // Degenerate T_RST=0 instance and illegal-state recovery
        reset_start(1'b0, 1'b1);
        repeat (4) step();
        check("deg_e4", obs2(), pk(1, 1, 0, 0, 1));
        step();
        check("deg_e5", obs2(), pk(2, 0, 0, 0, 1));
        step();
        check("deg_e6", obs2(), pk(3, 0, 1, 0, 1));
        repeat (3) step();
        check("deg_e9", obs2(), pk(4, 0, 1, 1, 0));
        dut2.r_state = 3'd7;
        step();
        check("illegal_to_off", obs2(), pk(0, 1, 0, 0, 0));
        step();
        check("illegal_then_up", obs2(), pk(1, 1, 0, 0, 1));

        // Random en bursts against the model
        reset_start(1'b0, 1'b0);
        for (int b = 0; b < 80; b++) begin
            en = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 16)) step();
        end
        en = 1'b0;
        repeat (4) step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
